// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared state type, frame field sizes and default sync marker for the UART boot loader
package uart_boot_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE  = 3'd0,
        BOOT_ADDR  = 3'd1,
        BOOT_COUNT = 3'd2,
        BOOT_DATA  = 3'd3,
        BOOT_WRITE = 3'd4,
        BOOT_CHECK = 3'd5,
        BOOT_DONE  = 3'd6,
        BOOT_ERROR = 3'd7
    } boot_state_e;

    localparam int ADDR_BYTES  = 4;
    localparam int COUNT_BYTES = 2;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// uart_rx_byte: 8N1 receiver with two-flop synchronizer, mid-bit sampling, byte valid pulse and framing error
module uart_rx_byte #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n_sync,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;
    localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);

    // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
    logic [2:0]  sync_q, sync_d;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    assign byte_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

    // bit timing: detect start edge, confirm it at half a bit, then sample each bit in its middle
    always_comb begin
        sync_d     = {sync_q[1:0], rx_i};
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !sync_q[1]) rx_state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_END) begin
                cnt_d      = '0;
                bit_d      = '0;
                rx_state_d = sync_q[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                shift_d = {sync_q[1], shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            default: if (cnt_q == BIT_END) begin
                rx_state_d = RX_IDLE;
                valid_d    = sync_q[1];
                ferr_d     = !sync_q[1];
            end
        endcase
    end

    // receiver registers; the synchronizer resets to the idle-high line level
    always_ff @(posedge clk or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            sync_q     <= 3'b111;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a framed UART image into instruction RAM, then raises the core fetch enable
// Optional feature: define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int         CLK_DIV   = 434,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset_n_sync,
    input  logic        uart_rx_input,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    output logic        fetch_enable_o,
    output logic        boot_busy_o,
    output logic        boot_error_o
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ferr;

    boot_state_e state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic        pend_q, pend_d;
    logic        err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
    logic        chk_got_q, chk_got_d;
`endif

    logic        in_valid;
    logic [7:0]  in_byte;
    logic        take;
    logic        pend_now;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk         (clk),
        .reset_n_sync(reset_n_sync),
        .rx_i        (uart_rx_input),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    assign mem_req_o      = state_q == BOOT_WRITE;
    assign mem_we_o       = mem_req_o;
    assign mem_be_o       = {4{mem_req_o}};
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = word_q;
    assign fetch_enable_o = state_q == BOOT_DONE;
    assign boot_busy_o    = !(state_q inside {BOOT_IDLE, BOOT_DONE, BOOT_ERROR});
    assign boot_error_o   = err_q;

    // frame parser: bytes bypass the buffer unless a write is pending, in which case one is held
    always_comb begin
        in_valid   = rx_valid || buf_full_q;
        in_byte    = buf_full_q ? buf_q : rx_byte;
        take       = in_valid && state_q != BOOT_WRITE;
        buf_full_d = state_q == BOOT_WRITE && (buf_full_q || rx_valid);
        buf_d      = (state_q == BOOT_WRITE && rx_valid && !buf_full_q) ? rx_byte : buf_q;
        pend_now   = pend_q || (state_q == BOOT_WRITE && (rx_ferr || (rx_valid && buf_full_q)));
        pend_d     = pend_now;
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        idx_d      = idx_q;
        case (state_q)
            BOOT_IDLE, BOOT_ERROR: if (take && in_byte == SYNC_BYTE) begin
                state_d = BOOT_ADDR;
                idx_d   = '0;
            end
            BOOT_ADDR: if (take) begin
                addr_d = {in_byte, addr_q[31:8]};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'(ADDR_BYTES - 1)) begin
                    addr_d[1:0] = 2'b00;
                    idx_d       = '0;
                    state_d     = BOOT_COUNT;
                end
            end
            BOOT_COUNT: if (take) begin
                cnt_d = {in_byte, cnt_q[15:8]};
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'(COUNT_BYTES - 1)) begin
                    idx_d   = '0;
                    state_d = (cnt_d == 16'd0) ? BOOT_CHECK : BOOT_DATA;
                end
            end
            BOOT_DATA: if (take) begin
                word_d = {in_byte, word_q[31:8]};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = BOOT_WRITE;
            end
            BOOT_WRITE: if (mem_gnt_i) begin
                addr_d  = addr_q + 32'd4;
                cnt_d   = cnt_q - 16'd1;
                pend_d  = 1'b0;
                state_d = pend_now ? BOOT_ERROR : (cnt_q == 16'd1) ? BOOT_CHECK : BOOT_DATA;
            end
            BOOT_CHECK: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (chk_got_q) state_d = (chk_q == 8'h00) ? BOOT_DONE : BOOT_ERROR;
`else
                state_d = BOOT_DONE;
`endif
            end
            default: ;
        endcase
        if (rx_ferr && state_q inside {BOOT_ADDR, BOOT_COUNT, BOOT_DATA, BOOT_CHECK, BOOT_ERROR})
            state_d = BOOT_ERROR;
        err_d = (state_d == BOOT_ERROR) ? 1'b1 : (state_d == BOOT_DONE) ? 1'b0 : err_q;
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    // running XOR over ADDR, COUNT, data and CHK bytes; a matching CHK leaves zero
    always_comb begin
        chk_d     = chk_q;
        chk_got_d = chk_got_q;
        if (state_d == BOOT_ADDR && state_q != BOOT_ADDR) begin
            chk_d     = '0;
            chk_got_d = 1'b0;
        end else if (take && state_q inside {BOOT_ADDR, BOOT_COUNT, BOOT_DATA}) begin
            chk_d = chk_q ^ in_byte;
        end else if (take && state_q == BOOT_CHECK && !chk_got_q) begin
            chk_d     = chk_q ^ in_byte;
            chk_got_d = 1'b1;
        end
    end

    // checksum registers
    always_ff @(posedge clk or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            chk_q     <= '0;
            chk_got_q <= 1'b0;
        end else begin
            chk_q     <= chk_d;
            chk_got_q <= chk_got_d;
        end
    end
`endif

    // loader state registers
    always_ff @(posedge clk or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            state_q    <= BOOT_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

endmodule
